// File: rtl/dds_pkg.sv
// Shared constants and helpers for the multi-channel DDS phase accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the dither LFSR seed/tap mask, the write-target encodings and a
// constant clog2 helper used to size the channel/segment select ports.
package dds_pkg;

  // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // iwr_tgt encodings.
  localparam logic TGT_FREQ = 1'b0;
  localparam logic TGT_POFF = 1'b1;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dds_phase_chan.sv
// One DDS channel: shadow/active frequency word and phase offset, phase accumulator, address register.
// Latency: acc updates every edge; owrap 1 cycle after the carrying add; oaddr 1 cycle after acc.
// Backpressure: none; writes, commits and clears are accepted every cycle.
//
// Ports:
//   iclk, irst          clock, synchronous active-high reset
//   iwr_en/tgt/seg/data pre-qualified byte write into a shadow register
//   icommit             shadow -> active copy for fword and poff
//   iphase_clr          zero the accumulator, suppress the carry
//   idither             value added to acc+poff before truncation (zero when dither is off)
//   oaddr, owrap        registered waveform address and carry pulse
module dds_phase_chan
  import dds_pkg::*;
#(
  parameter int PHASE_W   = 24,
  parameter int ADDR_W    = 11,
  parameter int FWORD_RST = 1,
  parameter int SEG_W     = 2,
  parameter int DITH_W    = 13
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              iwr_en,
  input  logic              iwr_tgt,
  input  logic [SEG_W-1:0]  iwr_seg,
  input  logic [7:0]        iwr_data,
  input  logic              icommit,
  input  logic              iphase_clr,
  input  logic [DITH_W-1:0] idither,
  output logic [ADDR_W-1:0] oaddr,
  output logic              owrap
);

  localparam logic [PHASE_W-1:0] FW_RST = PHASE_W'(FWORD_RST);

  logic [PHASE_W-1:0] sh_fword;
  logic [PHASE_W-1:0] sh_poff;
  logic [PHASE_W-1:0] fword;
  logic [PHASE_W-1:0] poff;
  logic [PHASE_W-1:0] acc;

  logic [PHASE_W-1:0] acc_sum;
  logic               acc_carry;
  logic [PHASE_W-1:0] addr_phase;

  // Natural carry of the modular add is the wrap indication.
  assign {acc_carry, acc_sum} = {1'b0, acc} + {1'b0, fword};
  // Output phase uses the current acc, so oaddr trails acc by one register.
  assign addr_phase = acc + poff + PHASE_W'(idither);

  // Shadow registers: a commit reads the pre-edge shadow, so a write in the
  // same cycle lands in the shadow only.
  always_ff @(posedge iclk) begin
    if (irst) begin
      sh_fword <= FW_RST;
      sh_poff  <= '0;
    end else if (iwr_en) begin
      if (iwr_tgt == TGT_FREQ) sh_fword[8*iwr_seg +: 8] <= iwr_data;
      else                     sh_poff[8*iwr_seg +: 8]  <= iwr_data;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      fword <= FW_RST;
      poff  <= '0;
    end else if (icommit) begin
      fword <= sh_fword;
      poff  <= sh_poff;
    end
  end

  // Clear overrides accumulation; the add after a clear+commit uses the new fword.
  always_ff @(posedge iclk) begin
    if (irst) begin
      acc   <= '0;
      owrap <= 1'b0;
      oaddr <= '0;
    end else begin
      if (iphase_clr) begin
        acc   <= '0;
        owrap <= 1'b0;
      end else begin
        acc   <= acc_sum;
        owrap <= acc_carry;
      end
      oaddr <= addr_phase[PHASE_W-1 -: ADDR_W];
    end
  end

endmodule

// File: rtl/dds_phase_accum_mc.sv
// Multi-channel DDS phase accumulator: byte-wide shadow writes, global commit/clear, per-channel address out.
// Latency: owrap 1 cycle after the carrying add; oaddr 1 cycle after the accumulator.
// Backpressure: none; every input is accepted every cycle.
//
// Ports:
//   iclk, irst       clock, synchronous active-high reset (highest priority)
//   iwr_en, iwr_ch, iwr_tgt, iwr_seg, iwr_data
//                    byte write into a channel's frequency-word or phase-offset shadow;
//                    out-of-range channel or segment is dropped
//   icommit          all channels copy shadow -> active
//   iphase_clr       all accumulators to zero
//   oaddr            channel n at [n*ADDR_W +: ADDR_W]
//   owrap            channel n carry pulse
// Build option: define DDS_DITHER_EN to add LFSR dither to the address path.
module dds_phase_accum_mc
  import dds_pkg::*;
#(
  parameter  int NCH       = 2,
  parameter  int PHASE_W   = 24,
  parameter  int ADDR_W    = 11,
  parameter  int FWORD_RST = 1,
  localparam int CH_W      = (NCH > 1) ? clog2(NCH) : 1,
  localparam int NSEG      = PHASE_W / 8,
  localparam int SEG_W     = (NSEG > 1) ? clog2(NSEG) : 1
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  iwr_en,
  input  logic [CH_W-1:0]       iwr_ch,
  input  logic                  iwr_tgt,
  input  logic [SEG_W-1:0]      iwr_seg,
  input  logic [7:0]            iwr_data,
  input  logic                  icommit,
  input  logic                  iphase_clr,
  output logic [NCH*ADDR_W-1:0] oaddr,
  output logic [NCH-1:0]        owrap
);

  // Dither covers at most the bits discarded by truncation, capped at the LFSR width.
  localparam int DITH_W = ((PHASE_W - ADDR_W) > 16) ? 16 : (PHASE_W - ADDR_W);

  logic              wr_ok;
  logic [DITH_W-1:0] dither;

  assign wr_ok = iwr_en && (32'(iwr_ch) < 32'(NCH)) && (32'(iwr_seg) < 32'(NSEG));

`ifdef DDS_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge iclk) begin
    if (irst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign dither = lfsr[DITH_W-1:0];
`else
  assign dither = '0;
`endif

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    logic ch_wr_en;

    assign ch_wr_en = wr_ok && (32'(iwr_ch) == n);

    dds_phase_chan #(
      .PHASE_W  (PHASE_W),
      .ADDR_W   (ADDR_W),
      .FWORD_RST(FWORD_RST),
      .SEG_W    (SEG_W),
      .DITH_W   (DITH_W)
    ) u_chan (
      .iclk      (iclk),
      .irst      (irst),
      .iwr_en    (ch_wr_en),
      .iwr_tgt   (iwr_tgt),
      .iwr_seg   (iwr_seg),
      .iwr_data  (iwr_data),
      .icommit   (icommit),
      .iphase_clr(iphase_clr),
      .idither   (dither),
      .oaddr     (oaddr[n*ADDR_W +: ADDR_W]),
      .owrap     (owrap[n])
    );
  end

endmodule

// File: tb/tb_dds_phase_accum_mc.sv
// Bench for dds_phase_accum_mc: directed scenarios plus random traffic against an arithmetic reference model.
// Latency: model predicts registered outputs one edge after the inputs it consumes.
// Backpressure: n/a.
module tb_dds_phase_accum_mc;

  localparam int NCH   = 2;
  localparam int PW    = 24;
  localparam int AW    = 11;
  localparam int FWR   = 1;
  localparam int CH_W  = $clog2(NCH);
  localparam int NSEG  = PW / 8;
  localparam int SEG_W = 2;
  localparam longint M = longint'(1) << PW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wr_en;
  logic [CH_W-1:0]      wr_ch;
  logic                 wr_tgt;
  logic [SEG_W-1:0]     wr_seg;
  logic [7:0]           wr_data;
  logic                 commit;
  logic                 clr;
  logic [NCH*AW-1:0]    oaddr;
  logic [NCH-1:0]       owrap;

  int total = 0;
  int bad   = 0;

  // Reference state, plain integers.
  longint sh_f[NCH], sh_p[NCH], fw[NCH], po[NCH], acc[NCH];
  longint m_addr[NCH];
  bit     m_wrap[NCH];

  always #5 clk = ~clk;

  dds_phase_accum_mc #(
    .NCH(NCH), .PHASE_W(PW), .ADDR_W(AW), .FWORD_RST(FWR)
  ) dut (
    .iclk      (clk),
    .irst      (rst),
    .iwr_en    (wr_en),
    .iwr_ch    (wr_ch),
    .iwr_tgt   (wr_tgt),
    .iwr_seg   (wr_seg),
    .iwr_data  (wr_data),
    .icommit   (commit),
    .iphase_clr(clr),
    .oaddr     (oaddr),
    .owrap     (owrap)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge of the behavioural model, using the inputs present at the edge.
  task automatic model_edge();
    longint s;
    int ch, seg;
    if (rst) begin
      for (int n = 0; n < NCH; n++) begin
        sh_f[n] = FWR; sh_p[n] = 0; fw[n] = FWR; po[n] = 0; acc[n] = 0;
        m_addr[n] = 0; m_wrap[n] = 0;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        m_addr[n] = ((acc[n] + po[n]) % M) >> (PW - AW);
        if (clr) begin
          acc[n] = 0; m_wrap[n] = 0;
        end else begin
          s = acc[n] + fw[n];
          m_wrap[n] = (s >= M);
          acc[n] = s % M;
        end
      end
      if (commit) begin
        for (int n = 0; n < NCH; n++) begin
          fw[n] = sh_f[n]; po[n] = sh_p[n];
        end
      end
      ch  = int'(wr_ch);
      seg = int'(wr_seg);
      if (wr_en && ch < NCH && seg < NSEG) begin
        if (wr_tgt == 1'b0)
          sh_f[ch] = (sh_f[ch] & ~(longint'(255) << (8*seg))) | (longint'(wr_data) << (8*seg));
        else
          sh_p[ch] = (sh_p[ch] & ~(longint'(255) << (8*seg))) | (longint'(wr_data) << (8*seg));
      end
    end
  endtask

  task automatic step();
    logic [NCH*AW-1:0] ea;
    logic [NCH-1:0]    ew;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int n = 0; n < NCH; n++) begin
      ea[n*AW +: AW] = AW'(m_addr[n]);
      ew[n]          = m_wrap[n];
    end
    chk("oaddr", 64'(oaddr), 64'(ea));
    chk("owrap", 64'(owrap), 64'(ew));
  endtask

  task automatic drive(input bit we, input int ch, input bit tgt, input int seg, input int d,
                       input bit cm, input bit cl, input bit r);
    wr_en   = we;
    wr_ch   = CH_W'(ch);
    wr_tgt  = tgt;
    wr_seg  = SEG_W'(seg);
    wr_data = 8'(d);
    commit  = cm;
    clr     = cl;
    rst     = r;
    step();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [AW-1:0] prev;

    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 2, 8'h55, 1, 0, 1);   // write+commit during reset: dropped
    chk("rst_addr", 64'(oaddr), 64'd0);
    chk("rst_wrap", 64'(owrap), 64'd0);

    // Default fword=1: ch0 address steps to 1 one cycle after acc hits 8192.
    for (int k = 1; k <= 8200; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      if (k == 8192) chk("def_addr_pre", 64'(oaddr[AW-1:0]), 64'd0);
      if (k == 8193) chk("def_addr_post", 64'(oaddr[AW-1:0]), 64'd1);
    end

    // ch1 fword 0x002000: one address step per cycle.
    drive(1, 1, 0, 0, 8'h00, 0, 0, 0);
    drive(1, 1, 0, 1, 8'h20, 0, 0, 0);
    drive(1, 1, 0, 3, 8'hff, 0, 0, 0);   // out-of-range segment
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      prev = oaddr[AW +: AW];
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("ch1_inc", 64'(oaddr[AW +: AW]), 64'(AW'(prev + 1)));
    end

    // ch0 fword 0x800000: half-cycle wrap.
    drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
    drive(1, 0, 0, 2, 8'h80, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    idle(8);

    // ch0 fword 0, poff 0x400000, commit with clear: address 512.
    drive(1, 0, 0, 2, 8'h00, 0, 0, 0);
    drive(1, 0, 1, 2, 8'h40, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("poff_512", 64'(oaddr[AW-1:0]), 64'd512);

    // Write alongside commit reaches the shadow only.
    drive(1, 0, 0, 2, 8'h10, 1, 0, 0);
    idle(3);
    chk("wr_commit_same", 64'(oaddr[AW-1:0]), 64'd512);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    chk("second_commit", 64'(oaddr[AW-1:0]), 64'd640);

    // Clear+commit of 0x002000, then reset in the middle of a write/commit.
    drive(1, 0, 0, 2, 8'h00, 0, 0, 0);
    drive(1, 0, 0, 1, 8'h20, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    idle(5);
    drive(1, 0, 0, 1, 8'h77, 0, 0, 0);
    drive(1, 1, 1, 0, 8'h33, 1, 1, 1);
    chk("mid_rst_addr", 64'(oaddr), 64'd0);
    chk("mid_rst_wrap", 64'(owrap), 64'd0);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, NCH - 1), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 255),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 255) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
